// File: rtl/device_table.sv
// device_table: read-mostly table describing every slave on the PI1 bus,
// plus three software-written reset/power-control bits.
// Word 2k holds (ID << 1) | useintr for entry k.
// Word 2k+1 holds entry k's region size in bytes.
// Words past the table read as zero.
module device_table #(
  parameter  int ARCHBITSZ = 32,
  parameter  int DEVMAPCNT = 2,
  localparam int CLOG2BYTES = $clog2(ARCHBITSZ/8),
  localparam int ADDRBITSZ  = ARCHBITSZ - CLOG2BYTES
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [1:0]                     pi1_op_i,
  input  logic [ADDRBITSZ-1:0]           pi1_addr_i,
  input  logic [ARCHBITSZ-1:0]           pi1_data_i,
  output logic [ARCHBITSZ-1:0]           pi1_data_o,
  input  logic [ARCHBITSZ/8-1:0]         pi1_sel_i,
  output logic                           pi1_rdy_o,
  output logic [ADDRBITSZ-1:0]           pi1_mapsz_o,
  output logic                           rst0_o,
  output logic                           rst1_o,
  output logic                           rst2_o,
  input  logic [ARCHBITSZ*DEVMAPCNT-1:0] devtbl_id_flat_i,
  input  logic [ADDRBITSZ*DEVMAPCNT-1:0] devtbl_mapsz_flat_i,
  input  logic [DEVMAPCNT-1:0]           devtbl_useintr_flat_i
);

  // Bus opcode bits: bit 0 requests a write, bit 1 requests a read.
  // Opcode 3 (swap) sets both bits.
  logic                 op_wr;
  logic                 op_rd;
  logic                 ctl_hit;
  logic [ARCHBITSZ-1:0] rd_word;

  assign op_wr   = pi1_op_i[0];
  assign op_rd   = pi1_op_i[1];
  assign ctl_hit = op_wr && (pi1_addr_i == '0) && pi1_sel_i[0];

  // The region is 4 KiB, expressed in words.
  // Every op completes in the cycle it is presented.
  assign pi1_mapsz_o = ADDRBITSZ'('h1000 / (ARCHBITSZ/8));
  assign pi1_rdy_o   = 1'b1;

  // Table word lookup, taken straight from the live table inputs.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < DEVMAPCNT; k++) begin
      if (pi1_addr_i == ADDRBITSZ'(2*k)) begin
        rd_word = {devtbl_id_flat_i[k*ARCHBITSZ +: ARCHBITSZ-1],
                   devtbl_useintr_flat_i[k]};
      end else if (pi1_addr_i == ADDRBITSZ'(2*k+1)) begin
        rd_word = ARCHBITSZ'(devtbl_mapsz_flat_i[k*ADDRBITSZ +: ADDRBITSZ]) << CLOG2BYTES;
      end
    end
  end

  // Registered read data and control bits.
  // On a swap, the read captures the table word and not the control bits.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pi1_data_o <= '0;
      rst0_o     <= 1'b0;
      rst1_o     <= 1'b0;
      rst2_o     <= 1'b0;
    end else begin
      if (op_rd) begin
        pi1_data_o <= rd_word;
      end
      if (ctl_hit) begin
        rst0_o <= pi1_data_i[0];
        rst1_o <= pi1_data_i[1];
        rst2_o <= pi1_data_i[2];
      end
    end
  end

endmodule

// File: tb/tb_device_table.sv
// Directed bench for device_table.
// It uses a vector table of single-cycle ops, followed by hand-written
// sequences for reset, swap, byte-enable and live table updates.
module tb_device_table;

  localparam int ARCHBITSZ = 32;
  localparam int DEVMAPCNT = 2;
  localparam int ADDRBITSZ = 30;

  logic                           clk_i = 1'b0;
  logic                           rst_i;
  logic [1:0]                     pi1_op_i;
  logic [ADDRBITSZ-1:0]           pi1_addr_i;
  logic [ARCHBITSZ-1:0]           pi1_data_i;
  logic [ARCHBITSZ-1:0]           pi1_data_o;
  logic [ARCHBITSZ/8-1:0]         pi1_sel_i;
  logic                           pi1_rdy_o;
  logic [ADDRBITSZ-1:0]           pi1_mapsz_o;
  logic                           rst0_o, rst1_o, rst2_o;
  logic [ARCHBITSZ*DEVMAPCNT-1:0] devtbl_id_flat_i;
  logic [ADDRBITSZ*DEVMAPCNT-1:0] devtbl_mapsz_flat_i;
  logic [DEVMAPCNT-1:0]           devtbl_useintr_flat_i;

  int n_tests = 0;
  int n_fail  = 0;

  device_table #(.ARCHBITSZ(ARCHBITSZ), .DEVMAPCNT(DEVMAPCNT)) dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .pi1_op_i              (pi1_op_i),
    .pi1_addr_i            (pi1_addr_i),
    .pi1_data_i            (pi1_data_i),
    .pi1_data_o            (pi1_data_o),
    .pi1_sel_i             (pi1_sel_i),
    .pi1_rdy_o             (pi1_rdy_o),
    .pi1_mapsz_o           (pi1_mapsz_o),
    .rst0_o                (rst0_o),
    .rst1_o                (rst1_o),
    .rst2_o                (rst2_o),
    .devtbl_id_flat_i      (devtbl_id_flat_i),
    .devtbl_mapsz_flat_i   (devtbl_mapsz_flat_i),
    .devtbl_useintr_flat_i (devtbl_useintr_flat_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  op;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] exp_data;
    logic [2:0]  exp_rst;   // {rst2, rst1, rst0}
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one op at the negedge and let the posedge sample it.
  // Outputs are then checked 1 time unit after that posedge.
  task automatic do_op(input string name, input logic rst_n, input logic [1:0] op,
                       input logic [29:0] addr, input logic [31:0] wdata,
                       input logic [3:0] sel, input logic [31:0] exp_data,
                       input logic [2:0] exp_rst);
    @(negedge clk_i);
    rst_i      = rst_n;
    pi1_op_i   = op;
    pi1_addr_i = addr;
    pi1_data_i = wdata;
    pi1_sel_i  = sel;
    @(posedge clk_i);
    #1;
    check({name, " data"},  pi1_data_o, exp_data);
    check({name, " rst"},   {29'd0, rst2_o, rst1_o, rst0_o}, {29'd0, exp_rst});
    check({name, " rdy"},   {31'd0, pi1_rdy_o}, 32'd1);
    check({name, " mapsz"}, {2'd0, pi1_mapsz_o}, 32'h400);
    @(negedge clk_i);
    rst_i    = 1'b1;
    pi1_op_i = 2'd0;
  endtask

  initial begin
    //                op     addr      wdata  sel      exp_data  exp_rst
    vecs[0]  = '{2'd2, 30'd0,     32'h0, 4'hF, 32'h9,    3'b000};
    vecs[1]  = '{2'd2, 30'd1,     32'h0, 4'hF, 32'h200,  3'b000};
    vecs[2]  = '{2'd2, 30'd2,     32'h0, 4'h0, 32'hE,    3'b000};
    vecs[3]  = '{2'd2, 30'd3,     32'h0, 4'hF, 32'h1000, 3'b000};
    vecs[4]  = '{2'd2, 30'd4,     32'h0, 4'hF, 32'h0,    3'b000};
    vecs[5]  = '{2'd2, 30'h3FF,   32'h0, 4'hF, 32'h0,    3'b000};
    vecs[6]  = '{2'd2, 30'd0,     32'h0, 4'hF, 32'h9,    3'b000};
    vecs[7]  = '{2'd0, 30'd3,     32'h0, 4'hF, 32'h9,    3'b000};
    vecs[8]  = '{2'd1, 30'd0,     32'h3, 4'h0, 32'h9,    3'b000};
    vecs[9]  = '{2'd1, 30'd5,     32'h3, 4'hF, 32'h9,    3'b000};
    vecs[10] = '{2'd1, 30'd0,     32'h1, 4'h1, 32'h9,    3'b001};

    devtbl_id_flat_i      = {32'd7, 32'd4};
    devtbl_mapsz_flat_i   = {30'h400, 30'h80};
    devtbl_useintr_flat_i = 2'b01;

    rst_i      = 1'b0;
    pi1_op_i   = 2'd0;
    pi1_addr_i = '0;
    pi1_data_i = '0;
    pi1_sel_i  = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check("reset data", pi1_data_o, 32'h0);
    check("reset rst", {29'd0, rst2_o, rst1_o, rst0_o}, 32'h0);
    check("reset rdy", {31'd0, pi1_rdy_o}, 32'd1);
    @(negedge clk_i);
    rst_i = 1'b1;

    for (int i = 0; i < 11; i++) begin
      do_op($sformatf("vec%0d", i), 1'b1, vecs[i].op, vecs[i].addr, vecs[i].wdata,
            vecs[i].sel, vecs[i].exp_data, vecs[i].exp_rst);
    end

    // A reset in the same cycle as a write wins: the control bits clear and the data clears.
    do_op("rst_vs_write", 1'b0, 2'd1, 30'd0, 32'h7, 4'h1, 32'h0, 3'b000);

    // A swap returns table word 0 and then writes rst1.
    do_op("swap", 1'b1, 2'd3, 30'd0, 32'h2, 4'h1, 32'h9, 3'b010);

    // A write with sel[0] clear is ignored, even when the other byte enables are set.
    do_op("sel_hi_only", 1'b1, 2'd1, 30'd0, 32'h5, 4'hE, 32'h9, 3'b010);

    // This write sets rst2 and rst0, and the read data holds.
    do_op("write5", 1'b1, 2'd1, 30'd0, 32'h5, 4'h1, 32'h9, 3'b101);

    // Table inputs are read live: change entry 1's ID to 9.
    devtbl_id_flat_i = {32'd9, 32'd4};
    do_op("live_id", 1'b1, 2'd2, 30'd2, 32'h0, 4'hF, 32'h12, 3'b101);

    // Change entry 0's useintr and mapsz, then read words 0 and 1.
    devtbl_useintr_flat_i = 2'b10;
    devtbl_mapsz_flat_i   = {30'h400, 30'h3};
    do_op("live_intr", 1'b1, 2'd2, 30'd0, 32'h0, 4'hF, 32'h8, 3'b101);
    do_op("live_mapsz", 1'b1, 2'd2, 30'd1, 32'h0, 4'hF, 32'hC, 3'b101);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
